// File: rtl/conveyor.sv
// Multi-channel conveyor: per-channel ring of result slots, allocated in program order and
// completed out of order by pipelined units. Optional same-cycle read bypass: CONVEYOR_BYPASS_EN.
`timescale 1ns/1ps

module conveyor #(
    parameter int unsigned WORD_MAG    = 5,
    parameter int unsigned DEPTH_MAG   = 4,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WRITE_PORTS = 2,
    localparam int unsigned WORD_WIDTH   = 1 << WORD_MAG,
    localparam int unsigned DEPTH        = 1 << DEPTH_MAG,
    localparam int unsigned CHANNEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CHANNEL_BITS-1:0]               channel,
    input  logic                                  alloc,
    output logic                                  alloc_ready,
    output logic [DEPTH_MAG-1:0]                  alloc_tag,
    input  logic [DEPTH_MAG-1:0]                  rd_index,
    output logic [WORD_WIDTH-1:0]                 rd_data,
    output logic                                  rd_valid,
    output logic                                  pending_any,
    input  logic                                  flush,
    input  logic [CHANNEL_BITS-1:0]               flush_channel,
    input  logic [WRITE_PORTS-1:0]                wr_en,
    input  logic [WRITE_PORTS*CHANNEL_BITS-1:0]   wr_channel,
    input  logic [WRITE_PORTS*DEPTH_MAG-1:0]      wr_tag,
    input  logic [WRITE_PORTS*WORD_WIDTH-1:0]     wr_data,
    output logic [WRITE_PORTS-1:0]                wr_drop
);

    localparam logic [DEPTH_MAG-1:0] OneTag = 1;

    logic [DEPTH_MAG-1:0]  head_q    [CHANNELS];
    logic [DEPTH_MAG-1:0]  head_d    [CHANNELS];
    logic [DEPTH-1:0]      pending_q [CHANNELS];
    logic [DEPTH-1:0]      pending_d [CHANNELS];
    logic [DEPTH-1:0]      done_q    [CHANNELS];
    logic [DEPTH-1:0]      done_d    [CHANNELS];
    logic [WORD_WIDTH-1:0] data_q    [CHANNELS][DEPTH];
    logic [WORD_WIDTH-1:0] data_d    [CHANNELS][DEPTH];
    logic [WRITE_PORTS-1:0] wr_drop_q, wr_drop_d;

    logic [CHANNEL_BITS-1:0] wr_ch  [WRITE_PORTS];
    logic [DEPTH_MAG-1:0]    wr_tg  [WRITE_PORTS];
    logic [WORD_WIDTH-1:0]   wr_wd  [WRITE_PORTS];
    logic [WRITE_PORTS-1:0]  wr_win;
    logic [DEPTH_MAG-1:0]    rd_slot;
    logic                    alloc_go;

    always_comb begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wr_ch[p] = wr_channel[p*CHANNEL_BITS +: CHANNEL_BITS];
            wr_tg[p] = wr_tag[p*DEPTH_MAG +: DEPTH_MAG];
            wr_wd[p] = wr_data[p*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign alloc_tag   = head_q[channel] - OneTag;
    assign rd_slot     = head_q[channel] + rd_index;
    assign alloc_ready = ~pending_q[channel][alloc_tag];
    assign pending_any = |pending_q[channel];
    assign alloc_go    = alloc && alloc_ready && !(flush && (flush_channel == channel));
    assign wr_drop     = wr_drop_q;

    // A write wins only if its slot is pending, its channel is not being flushed and no
    // lower-numbered port hits the same slot this cycle.
    always_comb begin
        wr_win = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wr_win[p] = wr_en[p] && pending_q[wr_ch[p]][wr_tg[p]]
                        && !(flush && (flush_channel == wr_ch[p]));
            for (int q = 0; q < p; q++) begin
                if (wr_en[q] && (wr_ch[q] == wr_ch[p]) && (wr_tg[q] == wr_tg[p])) begin
                    wr_win[p] = 1'b0;
                end
            end
        end
        wr_drop_d = wr_en & ~wr_win;
    end

    always_comb begin
        head_d    = head_q;
        pending_d = pending_q;
        done_d    = done_q;
        data_d    = data_q;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (wr_win[p]) begin
                pending_d[wr_ch[p]][wr_tg[p]] = 1'b0;
                done_d[wr_ch[p]][wr_tg[p]]    = 1'b1;
                data_d[wr_ch[p]][wr_tg[p]]    = wr_wd[p];
            end
        end
        // Alloc targets a non-pending slot, so it never collides with a winning write.
        if (alloc_go) begin
            head_d[channel]               = alloc_tag;
            pending_d[channel][alloc_tag] = 1'b1;
            done_d[channel][alloc_tag]    = 1'b0;
        end
        if (flush) begin
            head_d[flush_channel]    = '0;
            pending_d[flush_channel] = '0;
            done_d[flush_channel]    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                head_q[c]    <= '0;
                pending_q[c] <= '0;
                done_q[c]    <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    data_q[c][s] <= '0;
                end
            end
            wr_drop_q <= '0;
        end else begin
            head_q    <= head_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            data_q    <= data_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        rd_data  = data_q[channel][rd_slot];
        rd_valid = done_q[channel][rd_slot];
`ifdef CONVEYOR_BYPASS_EN
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (wr_win[p] && (wr_ch[p] == channel) && (wr_tg[p] == rd_slot)) begin
                rd_data  = wr_wd[p];
                rd_valid = 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_conveyor.sv
// Scoreboard bench for conveyor at default parameters (32-bit words, 16 slots, 2 channels,
// 2 write ports); expectations are queued with the stimulus and drained at each sample point.
`timescale 1ns/1ps

module tb_conveyor;

`ifdef CONVEYOR_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  channel;
    logic        alloc;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [3:0]  rd_index;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        pending_any;
    logic        flush;
    logic [0:0]  flush_channel;
    logic [1:0]  wr_en;
    logic [1:0]  wr_channel;
    logic [7:0]  wr_tag;
    logic [63:0] wr_data;
    logic [1:0]  wr_drop;

    conveyor dut (
        .clk           (clk),
        .reset         (reset),
        .channel       (channel),
        .alloc         (alloc),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .rd_index      (rd_index),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .pending_any   (pending_any),
        .flush         (flush),
        .flush_channel (flush_channel),
        .wr_en         (wr_en),
        .wr_channel    (wr_channel),
        .wr_tag        (wr_tag),
        .wr_data       (wr_data),
        .wr_drop       (wr_drop)
    );

    always #5 clk = ~clk;

    typedef enum int {SAllocReady, SAllocTag, SRdData, SRdValid, SPend, SDrop} sig_e;

    string       tag_q[$];
    sig_e        sig_q[$];
    logic [31:0] val_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input sig_e s, input logic [31:0] v);
        tag_q.push_back(tag);
        sig_q.push_back(s);
        val_q.push_back(v);
    endtask

    task automatic sample();
        string       t;
        sig_e        s;
        logic [31:0] v;
        logic [31:0] obs;
        while (sig_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sig_q.pop_front();
            v = val_q.pop_front();
            case (s)
                SAllocReady: obs = {31'd0, alloc_ready};
                SAllocTag:   obs = {28'd0, alloc_tag};
                SRdData:     obs = rd_data;
                SRdValid:    obs = {31'd0, rd_valid};
                SPend:       obs = {31'd0, pending_any};
                default:     obs = {30'd0, wr_drop};
            endcase
            check_eq(t, obs, v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        sample();
    endtask

    task automatic idle();
        alloc         = 1'b0;
        flush         = 1'b0;
        flush_channel = '0;
        wr_en         = '0;
        wr_channel    = '0;
        wr_tag        = '0;
        wr_data       = '0;
    endtask

    task automatic set_wr(input int p, input logic ch, input logic [3:0] tg, input logic [31:0] d);
        wr_en[p]             = 1'b1;
        wr_channel[p]        = ch;
        wr_tag[p*4 +: 4]     = tg;
        wr_data[p*32 +: 32]  = d;
    endtask

    initial begin
        reset    = 1'b1;
        channel  = '0;
        rd_index = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        expect_out("rst_ready", SAllocReady, 1);
        expect_out("rst_tag", SAllocTag, 15);
        expect_out("rst_valid", SRdValid, 0);
        expect_out("rst_pend", SPend, 0);
        expect_out("rst_drop", SDrop, 0);
        expect_out("rst_data", SRdData, 0);
        sample();
        reset = 1'b0;

        // Three allocs on channel 0: tags 15, 14, 13
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); channel = 0; alloc = 1'b1;
            expect_out("alloc_tag", SAllocTag, 32'(15 - i));
            samp();
        end
        cyc(); idle(); rd_index = 0;
        expect_out("new_slot_valid", SRdValid, 0);
        expect_out("pend_after_alloc", SPend, 1);
        expect_out("tag_after_3", SAllocTag, 12);
        samp();

        // Port 1 completes tag 14
        cyc(); idle(); set_wr(1, 1'b0, 4'd14, 32'hDEADBEEF); rd_index = 1;
        expect_out("same_cycle_valid", SRdValid, {31'd0, Bypass});
        expect_out("same_cycle_data", SRdData, Bypass ? 32'hDEADBEEF : 32'h0);
        samp();
        cyc(); idle(); rd_index = 1;
        expect_out("wr_data", SRdData, 32'hDEADBEEF);
        expect_out("wr_valid", SRdValid, 1);
        expect_out("wr_no_drop", SDrop, 0);
        samp();

        // Collision on tag 13: port 0 wins
        cyc(); idle(); set_wr(0, 1'b0, 4'd13, 32'h1); set_wr(1, 1'b0, 4'd13, 32'h2); rd_index = 0;
        expect_out("coll_byp_data", SRdData, Bypass ? 32'h1 : 32'h0);
        samp();
        cyc(); idle(); rd_index = 0;
        expect_out("coll_data", SRdData, 32'h1);
        expect_out("coll_valid", SRdValid, 1);
        expect_out("coll_drop", SDrop, 2);
        samp();

        // Writes to non-pending slots: unallocated 5 and already-done 14
        cyc(); idle(); set_wr(0, 1'b0, 4'd5, 32'h77); set_wr(1, 1'b0, 4'd14, 32'h88);
        cyc(); idle(); rd_index = 8;
        expect_out("np_drop", SDrop, 3);
        expect_out("np_valid", SRdValid, 0);
        samp();

        // Write to channel 1 is dropped and leaves channel 0 alone
        cyc(); idle(); set_wr(0, 1'b1, 4'd3, 32'h99);
        cyc(); idle(); channel = 0; rd_index = 1;
        expect_out("ch1_drop", SDrop, 1);
        expect_out("ch0_data_kept", SRdData, 32'hDEADBEEF);
        expect_out("ch0_valid_kept", SRdValid, 1);
        expect_out("ch0_pend", SPend, 1);
        samp();
        channel = 1; #1;
        expect_out("ch1_pend", SPend, 0);
        expect_out("ch1_tag", SAllocTag, 15);
        sample();

        // Fill channel 0 until slot 15 (still pending) blocks
        for (int i = 0; i < 13; i++) begin
            cyc(); idle(); channel = 0; alloc = 1'b1;
            expect_out("fill_tag", SAllocTag, 32'(12 - i));
            samp();
        end
        cyc(); idle(); channel = 0; alloc = 1'b1; rd_index = 0;
        expect_out("full_ready", SAllocReady, 0);
        expect_out("full_tag", SAllocTag, 15);
        expect_out("full_slot0_valid", SRdValid, 0);
        samp();
        cyc(); idle(); channel = 0;
        expect_out("ignored_ready", SAllocReady, 0);
        expect_out("ignored_tag", SAllocTag, 15);
        expect_out("ignored_pend", SPend, 1);
        samp();
        cyc(); idle(); channel = 0; set_wr(0, 1'b0, 4'd15, 32'h55);
        expect_out("ready_before_wr", SAllocReady, 0);
        samp();
        cyc(); idle(); channel = 0; alloc = 1'b1;
        expect_out("freed_ready", SAllocReady, 1);
        expect_out("freed_tag", SAllocTag, 15);
        samp();
        cyc(); idle(); channel = 0; rd_index = 0;
        expect_out("realloc_next_tag", SAllocTag, 14);
        expect_out("realloc_ready", SAllocReady, 1);
        expect_out("realloc_valid", SRdValid, 0);
        expect_out("realloc_data_kept", SRdData, 32'h55);
        samp();

        // Flush ch0 with a ch0 write and a ch1 alloc in the same cycle
        cyc(); idle(); flush = 1'b1; flush_channel = 0; set_wr(0, 1'b0, 4'd0, 32'hAA);
        channel = 1; alloc = 1'b1;
        cyc(); idle(); channel = 0;
        expect_out("flush_tag", SAllocTag, 15);
        expect_out("flush_ready", SAllocReady, 1);
        expect_out("flush_pend", SPend, 0);
        expect_out("flush_drop", SDrop, 1);
        samp();
        for (int i = 0; i < 16; i++) begin
            cyc(); idle(); channel = 0; rd_index = 4'(i);
            expect_out("flush_invalid", SRdValid, 0);
            samp();
        end
        cyc(); idle(); channel = 1;
        expect_out("ch1_alloc_tag", SAllocTag, 14);
        expect_out("ch1_alloc_pend", SPend, 1);
        samp();

        // Async reset mid-operation, with a drop pulse live
        cyc(); idle(); channel = 1; set_wr(0, 1'b1, 4'd2, 32'h1);
        cyc(); idle(); channel = 1; #1;
        expect_out("pre_rst_drop", SDrop, 1);
        expect_out("pre_rst_pend", SPend, 1);
        sample();
        reset = 1'b1; #1;
        expect_out("async_drop", SDrop, 0);
        expect_out("async_pend", SPend, 0);
        expect_out("async_tag", SAllocTag, 15);
        expect_out("async_ready", SAllocReady, 1);
        sample();
        cyc(); reset = 1'b0; idle(); channel = 1; set_wr(0, 1'b1, 4'd15, 32'h3);
        cyc(); idle(); channel = 1; rd_index = 0;
        expect_out("post_rst_drop", SDrop, 1);
        expect_out("post_rst_valid", SRdValid, 0);
        samp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
